// File: rtl/spi_regfile_slave_pkg.sv
// Shared definitions for the SPI register-file slave: idle MISO byte,
// bit-counter width and the LSB-first shift helper.
package spi_regfile_slave_pkg;

    localparam logic [7:0]  SPI_SLV_IDLE_MISO = 8'hFF;
    localparam int unsigned BITCNT_W          = 3;

    typedef logic [BITCNT_W-1:0] bitcnt_t;

    // Shift a byte right, entering the new bit at the MSB (LSB-first wire order).
    function automatic logic [7:0] shift_lsb_first(input logic [7:0] v, input logic b);
        return {b, v[7:1]};
    endfunction

endpackage

// File: rtl/spi_regfile_slave_sync.sv
// Two-flop synchroniser with one extra flop for edge detection.
// lvl is the synchronised level; rise/fall are single-cycle 0->1 / 1->0 pulses.
module spi_regfile_slave_sync
    import spi_regfile_slave_pkg::*;
(
    input  logic fclk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // Capture the asynchronous input; sr[2] holds the previous synchronised level.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[1:0], d};
        end
    end

    // Level and edge pulses derived from the synchronised value.
    always_comb begin
        lvl  = sr[1];
        rise = sr[1] & ~sr[2];
        fall = ~sr[1] & sr[2];
    end

endmodule

// File: rtl/spi_regfile_slave.sv
// AVR-side SPI slave exposing NREGS byte registers at regnums
// [REG_BASE, REG_BASE+NREGS), with burst auto-increment and per-byte strobes.
// Build option: SPI_SLV_RDBACK_EN makes masked registers read back wr_regs.
module spi_regfile_slave
    import spi_regfile_slave_pkg::*;
#(
    parameter int unsigned NREGS    = 16,
    parameter logic [7:0]  REG_BASE = 8'h80,
    parameter logic [7:0]  RST_VAL  = 8'h00
) (
    input  logic               fclk,
    input  logic               rst,
    input  logic               spics_n,
    input  logic               spick,
    input  logic               spido,
    output logic               spidi,
    input  logic [7:0]         status_in,
    input  logic [NREGS*8-1:0] rd_regs,
    output logic [NREGS*8-1:0] wr_regs,
    output logic [NREGS-1:0]   wr_stb,
    output logic [NREGS-1:0]   rd_stb,
    output logic               frame_end
);

    localparam int unsigned PTR_W  = $clog2(NREGS);
    localparam int unsigned WIN_LO = 32'(REG_BASE);
    localparam int unsigned WIN_HI = WIN_LO + NREGS;

    typedef logic [PTR_W-1:0] ptr_t;

    logic       cs_lvl, cs_rise, cs_fall;
    logic       sck_rise;
    logic [1:0] sck_unused;
    logic [1:0] sdo_sr;
    logic       sdo;

    logic [7:0] regnum;
    ptr_t       ptr;
    logic       valid;
    bitcnt_t    bitcnt;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic       adv;

    logic [NREGS*8-1:0] rd_src;
    ptr_t               fall_ptr, next_ptr;
    logic               in_win;
    logic [7:0]         fall_byte, next_byte, rx_byte;

    spi_regfile_slave_sync u_sync_cs (
        .fclk (fclk),
        .rst  (rst),
        .d    (spics_n),
        .lvl  (cs_lvl),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_regfile_slave_sync u_sync_sck (
        .fclk (fclk),
        .rst  (rst),
        .d    (spick),
        .lvl  (sck_unused[1]),
        .rise (sck_rise),
        .fall (sck_unused[0])
    );

    // MOSI needs no edge detect: two flops keep it aligned with the sck edge pulse.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            sdo_sr <= '0;
        end else begin
            sdo_sr <= {sdo_sr[0], spido};
        end
    end

`ifdef SPI_SLV_RDBACK_EN
    localparam logic [NREGS-1:0] RDBACK_MASK = '1;

    // Masked registers read back their own write value instead of rd_regs.
    always_comb begin
        rd_src = rd_regs;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (RDBACK_MASK[i]) begin
                rd_src[i*8 +: 8] = wr_regs[i*8 +: 8];
            end
        end
    end
`else
    // Read data always comes from the rd_regs inputs.
    always_comb begin
        rd_src = rd_regs;
    end
`endif

    // Window decode, pointer wrap and the byte sources for the shifter.
    always_comb begin
        sdo       = sdo_sr[1];
        fall_ptr  = PTR_W'(regnum - REG_BASE);
        in_win    = (32'(regnum) >= WIN_LO) && (32'(regnum) < WIN_HI);
        next_ptr  = (ptr == PTR_W'(NREGS - 1)) ? '0 : ptr + PTR_W'(1);
        fall_byte = rd_src[{fall_ptr, 3'b000} +: 8];
        next_byte = rd_src[{next_ptr, 3'b000} +: 8];
        rx_byte   = shift_lsb_first(shift_in, sdo);
        spidi     = shift_out[0];
    end

    // Framing, shifting, register commit and strobes; CS edges take priority over sck.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            regnum    <= '0;
            ptr       <= '0;
            valid     <= 1'b0;
            bitcnt    <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            adv       <= 1'b0;
            wr_regs   <= {NREGS{RST_VAL}};
            wr_stb    <= '0;
            rd_stb    <= '0;
            frame_end <= 1'b0;
        end else begin
            wr_stb    <= '0;
            rd_stb    <= '0;
            frame_end <= 1'b0;
            adv       <= 1'b0;
            if (cs_rise) begin
                regnum    <= '0;
                shift_out <= status_in;
                bitcnt    <= '0;
                frame_end <= valid;
                valid     <= 1'b0;
            end else if (cs_fall) begin
                ptr    <= fall_ptr;
                valid  <= in_win;
                bitcnt <= '0;
                if (in_win) begin
                    shift_out        <= fall_byte;
                    rd_stb[fall_ptr] <= 1'b1;
                end else begin
                    shift_out <= SPI_SLV_IDLE_MISO;
                end
            end else if (sck_rise) begin
                shift_out <= shift_lsb_first(shift_out, 1'b0);
                if (cs_lvl) begin
                    regnum <= shift_lsb_first(regnum, sdo);
                end else begin
                    shift_in <= rx_byte;
                    bitcnt   <= bitcnt + bitcnt_t'(1);
                    if (bitcnt == '1) begin
                        if (valid) begin
                            wr_regs[{ptr, 3'b000} +: 8] <= rx_byte;
                            wr_stb[ptr]                 <= 1'b1;
                            adv                         <= 1'b1;
                        end else begin
                            shift_out <= SPI_SLV_IDLE_MISO;
                        end
                    end
                end
            end else if (adv) begin
                ptr              <= next_ptr;
                shift_out        <= next_byte;
                rd_stb[next_ptr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed bench for spi_regfile_slave (NREGS=16, REG_BASE=8'h80).
// Strobe events are queued as stimulus is driven and checked as they appear.
module tb_spi_regfile_slave;

    localparam int NREGS = 16;
    localparam int HALF  = 80;

    logic               fclk = 1'b0;
    logic               rst;
    logic               spics_n;
    logic               spick;
    logic               spido;
    logic               spidi;
    logic [7:0]         status_in;
    logic [NREGS*8-1:0] rd_regs;
    logic [NREGS*8-1:0] wr_regs;
    logic [NREGS-1:0]   wr_stb;
    logic [NREGS-1:0]   rd_stb;
    logic               frame_end;

    logic [7:0] rd_mem   [NREGS];
    logic [7:0] model_wr [NREGS];

    typedef struct packed {
        int         idx;
        logic [7:0] data;
    } wr_ev_t;

    wr_ev_t wr_q[$];
    int     rd_q[$];
    wr_ev_t mon_e;
    int     mon_r;

    int checks   = 0;
    int failures = 0;
    int fe_seen  = 0;
    int fe_exp   = 0;

    logic       bit_unused;
    logic [7:0] rx;

    spi_regfile_slave #(
        .NREGS    (NREGS),
        .REG_BASE (8'h80),
        .RST_VAL  (8'h00)
    ) dut (
        .fclk      (fclk),
        .rst       (rst),
        .spics_n   (spics_n),
        .spick     (spick),
        .spido     (spido),
        .spidi     (spidi),
        .status_in (status_in),
        .rd_regs   (rd_regs),
        .wr_regs   (wr_regs),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb),
        .frame_end (frame_end)
    );

    always #5 fclk = ~fclk;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rd_regs[i*8 +: 8] = rd_mem[i];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) v[i*8 +: 8] = model_wr[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_rd(input int i);
`ifdef SPI_SLV_RDBACK_EN
        return model_wr[i];
`else
        return rd_mem[i];
`endif
    endfunction

    // Strobe / frame_end monitor, sampled on the inactive clock edge.
    always @(negedge fclk) begin
        if (!rst) begin
            if (wr_stb != '0 || rd_stb != '0) chk("stb_overlap", wr_stb & rd_stb, 0);
            if (wr_stb != '0) begin
                if (wr_q.size() == 0) begin
                    chk("wr_stb_unexpected", wr_stb, 0);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("wr_stb", wr_stb, 16'd1 << mon_e.idx);
                    chk("wr_data", wr_regs[mon_e.idx*8 +: 8], mon_e.data);
                end
            end
            if (rd_stb != '0) begin
                if (rd_q.size() == 0) begin
                    chk("rd_stb_unexpected", rd_stb, 0);
                end else begin
                    mon_r = rd_q.pop_front();
                    chk("rd_stb", rd_stb, 16'd1 << mon_r);
                end
            end
            if (frame_end) fe_seen++;
        end
    end

    task automatic spi_bit(input logic mosi, output logic miso);
        spido = mosi;
        #(HALF);
        miso  = spidi;
        spick = 1'b1;
        #(HALF);
        spick = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxb);
        logic b;
        for (int i = 0; i < 8; i++) begin
            spi_bit(tx[i], b);
            rxb[i] = b;
        end
    endtask

    task automatic cs_fall();
        spics_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_rise();
        spics_n = 1'b1;
        #(HALF);
    endtask

    // Full frame: address phase, n data bytes, CS_n rise; checks MISO and state.
    task automatic frame(input string tag, input logic [7:0] addr, input int n,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] exp_status);
        logic [7:0] r, d, exp_b;
        int         p;
        logic       win;
        spi_byte(addr, r);
        chk({tag, "_status"}, r, exp_status);
        win = (addr >= 8'h80) && (addr < 8'h90);
        p   = int'(addr) - 128;
        if (win) rd_q.push_back(p);
        cs_fall();
        for (int k = 0; k < n; k++) begin
            d     = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            exp_b = win ? exp_rd(p) : 8'hFF;
            if (win) begin
                wr_q.push_back('{p, d});
                rd_q.push_back((p + 1) % NREGS);
            end
            spi_byte(d, r);
            if (win) begin
                model_wr[p] = d;
                p = (p + 1) % NREGS;
            end
            chk({tag, "_miso"}, r, exp_b);
        end
        if (win) fe_exp++;
        cs_rise();
        chk({tag, "_frame_end"}, fe_seen, fe_exp);
        chk({tag, "_regs"}, wr_regs, model_vec());
    endtask

    initial begin
        rst       = 1'b1;
        spics_n   = 1'b1;
        spick     = 1'b0;
        spido     = 1'b0;
        status_in = 8'h5C;
        for (int i = 0; i < NREGS; i++) begin
            rd_mem[i]   = 8'hC0 + 8'(i);
            model_wr[i] = 8'h00;
        end
        rd_mem[5] = 8'h3C;
        #100;
        chk("rst_regs", wr_regs, model_vec());
        chk("rst_spidi", spidi, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_rd_stb", rd_stb, 0);
        chk("rst_frame_end", frame_end, 0);
        rst = 1'b0;
        #(HALF);

        // Reset mid-frame: the remaining bits must not commit anything.
        spi_byte(8'h83, rx);
        chk("pre_status", rx, 8'h5C);
        rd_q.push_back(3);
        cs_fall();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, bit_unused);
        rst = 1'b1;
        #50;
        chk("midrst_regs", wr_regs, model_vec());
        chk("midrst_spidi", spidi, 0);
        chk("midrst_stb", {wr_stb, rd_stb}, 0);
        rst = 1'b0;
        #(HALF);
        for (int i = 0; i < 13; i++) spi_bit(1'b1, bit_unused);
        cs_rise();
        chk("midrst_frame_end", fe_seen, fe_exp);
        chk("midrst_regs_after", wr_regs, model_vec());

        frame("wr3",    8'h83, 1, 8'hA5, 8'h00, 8'h00, 8'h5C);
        frame("burst",  8'h8E, 3, 8'h11, 8'h22, 8'h33, 8'h5C);
        frame("rd5",    8'h85, 1, 8'h69, 8'h00, 8'h00, 8'h5C);
        frame("oow",    8'h40, 2, 8'h55, 8'hAA, 8'h00, 8'h5C);
        frame("top",    8'h8F, 1, 8'hE7, 8'h00, 8'h00, 8'h5C);
        frame("oow_hi", 8'h90, 1, 8'h12, 8'h00, 8'h00, 8'h5C);
        frame("oow_lo", 8'h7F, 1, 8'h34, 8'h00, 8'h00, 8'h5C);

        // Partial byte: no write, frame_end still pulses, new status on next frame.
        spi_byte(8'h81, rx);
        chk("part_status", rx, 8'h5C);
        rd_q.push_back(1);
        cs_fall();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, bit_unused);
        status_in = 8'h9A;
        fe_exp++;
        cs_rise();
        chk("part_frame_end", fe_seen, fe_exp);
        chk("part_regs", wr_regs, model_vec());

        frame("wr2", 8'h82, 1, 8'h77, 8'h00, 8'h00, 8'h9A);
        frame("rd2", 8'h82, 1, 8'h00, 8'h00, 8'h00, 8'h9A);

        #(HALF * 4);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("frame_end_total", fe_seen, fe_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
